// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war match controller.
package tow_pkg;

    // Width of each player's round-win score (holds 0..7).
    localparam int SCORE_W = 3;

    // Width of the between-round hold down-counter (HOLD_CYCLES up to 255).
    localparam int HOLD_W = 8;

    // Match controller states.
    typedef enum logic [1:0] {
        START = 2'd0,
        PLAY  = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } tow_state_e;

endpackage

// File: rtl/score_seg7.sv
// Active-low 7-segment decoder for a 3-bit score; bit 0 drives segment a.
module score_seg7
    import tow_pkg::*;
(
    input  logic [SCORE_W-1:0] score_i,
    output logic [6:0]         seg_o
);

    // Pure combinational digit lookup, segments ordered {g,f,e,d,c,b,a}.
    always_comb begin
        seg_o = 7'b1111111;
        case (score_i)
            3'd0: seg_o = 7'b1000000;
            3'd1: seg_o = 7'b1111001;
            3'd2: seg_o = 7'b0100100;
            3'd3: seg_o = 7'b0110000;
            3'd4: seg_o = 7'b0011001;
            3'd5: seg_o = 7'b0010010;
            3'd6: seg_o = 7'b0000010;
            3'd7: seg_o = 7'b1111000;
            default: seg_o = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/tow_match_ctrl.sv
// Best-of-N match controller for the tug-of-war playfield: counts round wins,
// holds the playfield in reset between rounds and latches the champion.
//
// Handshake: L_win / R_win are single-cycle pulses with no back-pressure; they
// are consumed only on an edge where the controller is in PLAY and are dropped
// otherwise. new_match is a level/pulse consumed only in DONE.
module tow_match_ctrl
    import tow_pkg::*;
#(
    parameter int WINS_NEEDED = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               L_win,
    input  logic               R_win,
    input  logic               new_match,
    output logic               round_rst,
    output logic [SCORE_W-1:0] L_score,
    output logic [SCORE_W-1:0] R_score,
    output logic               match_over,
    output logic               L_champ,
    output logic               R_champ,
    output logic [6:0]         HEX_L,
    output logic [6:0]         HEX_R,
    output logic [1:0]         dbg_state
);

    localparam logic [SCORE_W-1:0] WINS_VAL  = SCORE_W'(WINS_NEEDED);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

    tow_state_e         state_q, state_d;
    logic [SCORE_W-1:0] l_score_q, l_score_d;
    logic [SCORE_W-1:0] r_score_q, r_score_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               round_rst_q, round_rst_d;
    logic               match_over_q, match_over_d;
    logic               l_champ_q, l_champ_d;
    logic               r_champ_q, r_champ_d;

    // Next-state, score and hold-counter decisions; outputs are derived from
    // the next state so the registered outputs never lag the state.
    always_comb begin
        state_d   = state_q;
        l_score_d = l_score_q;
        r_score_d = r_score_q;
        hold_d    = hold_q;
        l_champ_d = l_champ_q;
        r_champ_d = r_champ_q;
        case (state_q)
            START: begin
                state_d = PLAY;
            end
            PLAY: begin
                if (L_win && R_win) begin
                    // Tie: round is replayed, scores untouched.
                    state_d = HOLD;
                    hold_d  = HOLD_LOAD;
                end else if (L_win) begin
                    l_score_d = l_score_q + 1'b1;
                    if (l_score_d == WINS_VAL) begin
                        state_d   = DONE;
                        l_champ_d = 1'b1;
                    end else begin
                        state_d = HOLD;
                        hold_d  = HOLD_LOAD;
                    end
                end else if (R_win) begin
                    r_score_d = r_score_q + 1'b1;
                    if (r_score_d == WINS_VAL) begin
                        state_d   = DONE;
                        r_champ_d = 1'b1;
                    end else begin
                        state_d = HOLD;
                        hold_d  = HOLD_LOAD;
                    end
                end
            end
            HOLD: begin
                // Counter value N means N more cycles of round reset remain.
                if (hold_q <= HOLD_W'(1)) begin
                    state_d = PLAY;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            DONE: begin
                if (new_match) begin
                    state_d   = START;
                    l_score_d = '0;
                    r_score_d = '0;
                    l_champ_d = 1'b0;
                    r_champ_d = 1'b0;
                end
            end
            default: begin
                state_d = START;
            end
        endcase
        round_rst_d  = (state_d != PLAY);
        match_over_d = (state_d == DONE);
    end

    // All controller state, including the registered outputs, in one block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= START;
            l_score_q    <= '0;
            r_score_q    <= '0;
            hold_q       <= '0;
            round_rst_q  <= 1'b1;
            match_over_q <= 1'b0;
            l_champ_q    <= 1'b0;
            r_champ_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            l_score_q    <= l_score_d;
            r_score_q    <= r_score_d;
            hold_q       <= hold_d;
            round_rst_q  <= round_rst_d;
            match_over_q <= match_over_d;
            l_champ_q    <= l_champ_d;
            r_champ_q    <= r_champ_d;
        end
    end

    assign round_rst  = round_rst_q;
    assign L_score    = l_score_q;
    assign R_score    = r_score_q;
    assign match_over = match_over_q;
    assign L_champ    = l_champ_q;
    assign R_champ    = r_champ_q;
    assign dbg_state  = state_q;

    score_seg7 u_seg_l (
        .score_i (l_score_q),
        .seg_o   (HEX_L)
    );

    score_seg7 u_seg_r (
        .score_i (r_score_q),
        .seg_o   (HEX_R)
    );

endmodule

// File: tb/tb_tow_match_ctrl.sv
// Directed bench for tow_match_ctrl with a cycle-level reference model.
module tb_tow_match_ctrl;
    import tow_pkg::*;

    localparam int WINS = 4;
    localparam int HOLD_N = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    logic L_win, R_win, new_match;
    logic round_rst, match_over, L_champ, R_champ;
    logic [2:0] L_score, R_score;
    logic [6:0] HEX_L, HEX_R;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    tow_match_ctrl #(.WINS_NEEDED(WINS), .HOLD_CYCLES(HOLD_N)) dut (
        .clk        (clk),
        .reset      (reset),
        .L_win      (L_win),
        .R_win      (R_win),
        .new_match  (new_match),
        .round_rst  (round_rst),
        .L_score    (L_score),
        .R_score    (R_score),
        .match_over (match_over),
        .L_champ    (L_champ),
        .R_champ    (R_champ),
        .HEX_L      (HEX_L),
        .HEX_R      (HEX_R),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    // ---------------- reference model ----------------
    // The match is described as: scores, a champion, a "match over" flag and
    // the number of upcoming cycles the playfield must still be held in reset
    // before play resumes. Round reset is visible whenever the match is over
    // or that count is nonzero.
    int m_l = 0;
    int m_r = 0;
    bit m_over = 1'b0;
    bit m_lch = 1'b0;
    bit m_rch = 1'b0;
    int m_rst_left = 1;
    logic [6:0] seg_tab [0:7];

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
        seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_l <= 0; m_r <= 0; m_over <= 1'b0; m_lch <= 1'b0; m_rch <= 1'b0;
            m_rst_left <= 1;
        end else if (m_over) begin
            if (new_match) begin
                m_l <= 0; m_r <= 0; m_lch <= 1'b0; m_rch <= 1'b0;
                m_over <= 1'b0; m_rst_left <= 1;
            end
        end else if (m_rst_left > 0) begin
            m_rst_left <= m_rst_left - 1;
        end else if (L_win && R_win) begin
            m_rst_left <= HOLD_N;
        end else if (L_win) begin
            m_l <= m_l + 1;
            if (m_l + 1 == WINS) begin m_over <= 1'b1; m_lch <= 1'b1; end
            else m_rst_left <= HOLD_N;
        end else if (R_win) begin
            m_r <= m_r + 1;
            if (m_r + 1 == WINS) begin m_over <= 1'b1; m_rch <= 1'b1; end
            else m_rst_left <= HOLD_N;
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("round_rst", round_rst, (m_over || m_rst_left > 0));
            check("match_over", match_over, m_over);
            check("L_champ", L_champ, m_lch);
            check("R_champ", R_champ, m_rch);
            check("L_score", L_score, m_l);
            check("R_score", R_score, m_r);
            check("HEX_L", HEX_L, seg_tab[m_l[2:0]]);
            check("HEX_R", HEX_R, seg_tab[m_r[2:0]]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic l, input logic r);
        L_win = l;
        R_win = r;
        tick(1);
        L_win = 1'b0;
        R_win = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1;
        L_win = 1'b0;
        R_win = 1'b0;
        new_match = 1'b0;
        tick(2);
        cmp_en = 1'b1;

        // Reset values
        check("rst_round_rst", round_rst, 1);
        check("rst_L_score", L_score, 0);
        check("rst_match_over", match_over, 0);
        check("rst_HEX_L", HEX_L, 7'b1000000);

        // Release: one more START cycle, then PLAY
        reset = 1'b0;
        #3;
        check("start_round_rst", round_rst, 1);
        tick(1);
        check("play_round_rst", round_rst, 0);
        check("play_state", dbg_state, PLAY);

        // Left wins a round, hold 8 cycles; a left pulse mid-hold is ignored
        tick(1);
        pulse(1'b1, 1'b0);
        check("lwin_L_score", L_score, 1);
        check("lwin_round_rst", round_rst, 1);
        check("lwin_HEX_L", HEX_L, 7'b1111001);
        pulse(1'b1, 1'b0);
        tick(6);
        check("hold8_round_rst", round_rst, 1);
        check("hold_ignore_L", L_score, 1);
        tick(1);
        check("hold_end_round_rst", round_rst, 0);

        // Tie round
        pulse(1'b1, 1'b1);
        check("tie_round_rst", round_rst, 1);
        check("tie_L_score", L_score, 1);
        check("tie_R_score", R_score, 0);
        tick(7);
        check("tie_hold8", round_rst, 1);
        tick(1);
        check("tie_play", round_rst, 0);

        // new_match in PLAY is ignored
        new_match = 1'b1;
        tick(1);
        new_match = 1'b0;
        check("nm_play_L_score", L_score, 1);
        check("nm_play_round_rst", round_rst, 0);

        // Right takes four rounds and the match
        for (int i = 0; i < 4; i++) begin
            pulse(1'b0, 1'b1);
            if (i < 3) tick(HOLD_N);
        end
        check("rmatch_R_score", R_score, 4);
        check("rmatch_over", match_over, 1);
        check("rmatch_R_champ", R_champ, 1);
        check("rmatch_L_champ", L_champ, 0);
        check("rmatch_HEX_R", HEX_R, 7'b0011001);
        pulse(1'b1, 1'b0);
        tick(2);
        check("done_ignore_L", L_score, 1);
        check("done_state", dbg_state, DONE);

        // new_match in DONE
        new_match = 1'b1;
        tick(1);
        new_match = 1'b0;
        check("nm_done_L_score", L_score, 0);
        check("nm_done_R_score", R_score, 0);
        check("nm_done_R_champ", R_champ, 0);
        check("nm_done_over", match_over, 0);
        check("nm_done_round_rst", round_rst, 1);
        tick(1);
        check("nm_done_play", round_rst, 0);

        // Reset mid-hold with L_score=2
        pulse(1'b1, 1'b0);
        tick(HOLD_N);
        pulse(1'b1, 1'b0);
        check("pre_rst_L_score", L_score, 2);
        check("pre_rst_HEX_L", HEX_L, 7'b0100100);
        tick(3);
        #2;
        reset = 1'b1;
        #1;
        check("async_L_score", L_score, 0);
        check("async_round_rst", round_rst, 1);
        check("async_HEX_L", HEX_L, 7'b1000000);
        check("async_state", dbg_state, START);
        tick(2);
        reset = 1'b0;
        #1;
        check("rel_round_rst", round_rst, 1);
        tick(1);
        check("rel_play", round_rst, 0);

        // Left takes the match; right pulse in DONE ignored
        for (int i = 0; i < 4; i++) begin
            pulse(1'b1, 1'b0);
            if (i < 3) tick(HOLD_N);
        end
        check("lmatch_L_score", L_score, 4);
        check("lmatch_L_champ", L_champ, 1);
        check("lmatch_R_champ", R_champ, 0);
        check("lmatch_over", match_over, 1);
        pulse(1'b0, 1'b1);
        tick(1);
        check("done_ignore_R", R_score, 0);
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
